// File: rtl/store_buffer.sv
// Store buffer between the AGU and the D-cache: circular queue with head/commit/tail pointers
// and a two-state drain FSM. Define STORE_FWD_EN to add the load-forwarding search port.
module store_buffer #(
  parameter int unsigned SB_DEPTH = 8
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        SBAble,
  input  logic [7:0]  SBMicOp,
  input  logic [31:0] SBWDate,
  input  logic [1:0]  SBMAT,
  input  logic [31:0] SBPAddr,
  input  logic        SBTrap,
  input  logic [6:0]  SBTrapCode,
  input  logic [5:0]  SBRobPtr,
  output logic        SBFull,
  output logic        ToRobAble,
  output logic [5:0]  ToRobPtr,
  output logic        ToRobTrap,
  output logic [6:0]  ToRobTrapCode,
  input  logic        CommitStore,
  input  logic        SBFlash,
  output logic        ToCacheReq,
  output logic [31:0] ToCacheAddr,
  output logic [31:0] ToCacheData,
  output logic [3:0]  ToCacheMask,
  output logic [1:0]  ToCacheMAT,
  input  logic        CacheAck,
`ifdef STORE_FWD_EN
  input  logic [31:0] LdQAddr,
  output logic        LdQHit,
  output logic [31:0] LdQData,
  output logic        LdQConflict,
`endif
  output logic        SBEmpty
);

  localparam int unsigned IW = $clog2(SB_DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, commit_q, commit_d, tail_q, tail_d;

  logic [29:0]     addr_q [SB_DEPTH];
  logic [31:0]     data_q [SB_DEPTH];
  logic [3:0]      mask_q [SB_DEPTH];
  logic [1:0]      mat_q  [SB_DEPTH];

  logic            rob_able_q, rob_trap_q;
  logic [5:0]      rob_ptr_q;
  logic [6:0]      rob_code_q;

  logic            full, enq, commit_ok, pop;
  logic [31:0]     fmt_data;
  logic [3:0]      fmt_mask;
  logic [IW-1:0]   head_idx, tail_idx;

  logic unused_microp;
  assign unused_microp = ^SBMicOp[7:2];

  assign head_idx  = head_q[IW-1:0];
  assign tail_idx  = tail_q[IW-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
  assign SBFull    = full;
  assign SBEmpty   = (head_q == tail_q);
  assign enq       = SBAble & ~SBTrap & ~full & ~SBFlash;
  assign commit_ok = CommitStore & (commit_q != tail_q);
  assign pop       = (state_q == StReq) & CacheAck;

  // Data is replicated into every lane so the mask alone selects the written bytes.
  always_comb begin
    fmt_data = SBWDate;
    fmt_mask = 4'b1111;
    unique case (SBMicOp[1:0])
      2'b00: begin
        fmt_data = {4{SBWDate[7:0]}};
        fmt_mask = 4'b0001 << SBPAddr[1:0];
      end
      2'b01: begin
        fmt_data = {2{SBWDate[15:0]}};
        fmt_mask = 4'b0011 << SBPAddr[1:0];
      end
      default: begin
        fmt_data = SBWDate;
        fmt_mask = 4'b1111 << SBPAddr[1:0];
      end
    endcase
  end

  // Flush rewinds tail onto the post-commit pointer, discarding speculative stores.
  always_comb begin
    head_d   = head_q + PW'(pop);
    commit_d = commit_q + PW'(commit_ok);
    tail_d   = SBFlash ? commit_d : tail_q + PW'(enq);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (head_q != commit_q) state_d = StReq;
      StReq:   if (CacheAck) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ToCacheReq  = (state_q == StReq);
    ToCacheAddr = '0;
    ToCacheData = '0;
    ToCacheMask = '0;
    ToCacheMAT  = '0;
    if (state_q == StReq) begin
      ToCacheAddr = {addr_q[head_idx], 2'b00};
      ToCacheData = data_q[head_idx];
      ToCacheMask = mask_q[head_idx];
      ToCacheMAT  = mat_q[head_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q    <= StIdle;
      head_q     <= '0;
      commit_q   <= '0;
      tail_q     <= '0;
      rob_able_q <= 1'b0;
      rob_trap_q <= 1'b0;
      rob_ptr_q  <= '0;
      rob_code_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      commit_q   <= commit_d;
      tail_q     <= tail_d;
      // Stores dropped by flush or a full queue are never reported.
      rob_able_q <= SBAble & ~SBFlash & (SBTrap | ~full);
      if (SBAble) begin
        rob_ptr_q  <= SBRobPtr;
        rob_trap_q <= SBTrap;
        rob_code_q <= SBTrapCode;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      addr_q[tail_idx] <= SBPAddr[31:2];
      data_q[tail_idx] <= fmt_data;
      mask_q[tail_idx] <= fmt_mask;
      mat_q[tail_idx]  <= SBMAT;
    end
  end

  assign ToRobAble     = rob_able_q;
  assign ToRobPtr      = rob_ptr_q;
  assign ToRobTrap     = rob_trap_q;
  assign ToRobTrapCode = rob_code_q;

`ifdef STORE_FWD_EN
  logic [PW-1:0] count;
  logic [IW-1:0] fwd_idx;
  logic          fwd_found;
  logic [3:0]    fwd_mask;
  logic [31:0]   fwd_data;
  logic          unused_ldq;

  assign count      = tail_q - head_q;
  assign unused_ldq = ^LdQAddr[1:0];

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_found = 1'b0;
    fwd_mask  = '0;
    fwd_data  = '0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_idx + IW'(i);
      if ((PW'(i) < count) && (addr_q[fwd_idx] == LdQAddr[31:2])) begin
        fwd_found = 1'b1;
        fwd_mask  = mask_q[fwd_idx];
        fwd_data  = data_q[fwd_idx];
      end
    end
    LdQHit      = fwd_found && (fwd_mask == 4'b1111);
    LdQConflict = fwd_found && (fwd_mask != 4'b1111);
    LdQData     = LdQHit ? fwd_data : '0;
  end
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 8, number of entries (power of two, 4..16).
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port Rest  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports SBAble/SBMicOp/SBWDate/SBMAT/SBPAddr  in  1/8/32/2/32  store from AGU stage (valid, micro-op, write data, memory access type, physical address).
REQ-005 SHALL have ports SBTrap/SBTrapCode/SBRobPtr  in  1/7/6  TLB trap flag, trap code, ROB index of the store.
REQ-006 SHALL have port SBFull  out  1  AGU stall request; high when no free entry.
REQ-007 SHALL have ports ToRobAble/ToRobPtr/ToRobTrap/ToRobTrapCode  out  1/6/1/7  store completion report to ROB.
REQ-008 SHALL have ports CommitStore  in  1  ROB retires the oldest uncommitted store; SBFlash  in  1  pipeline flush.
REQ-009 SHALL have ports ToCacheReq/ToCacheAddr/ToCacheData/ToCacheMask/ToCacheMAT  out  1/32/32/4/2  drain request to D-cache; CacheAck  in  1  request accepted.
REQ-010 SHALL have ports SBEmpty  out  1  no valid entry (used for fences/idle).

Function
REQ-011 Circular FIFO with head (oldest), commit (first uncommitted), tail (next free) pointers, each log2(SB_DEPTH)+1 bits with wrap bit.
REQ-012 Enqueue when SBAble=1, SBTrap=0, not full: entry written at tail, tail+1, entry uncommitted.
REQ-013 SBAble=1 with SBTrap=1: no entry allocated; trap reported to ROB only.
REQ-014 Every SBAble=1 SHALL produce exactly one ToRobAble pulse the next cycle with ToRobPtr=SBRobPtr, ToRobTrap/TrapCode copied.
REQ-015 Size from SBMicOp[1:0]: 00 byte, 01 half, 10 word; 11 treated as word. Mask = 0001/0011/1111 shifted by SBPAddr[1:0]; data replicated into byte lanes accordingly; ToCacheAddr = {SBPAddr[31:2],2'b00}.
REQ-016 CommitStore=1 advances commit pointer by one; if commit==tail it is ignored.
REQ-017 Drain FSM states IDLE, REQ. IDLE->REQ when head!=commit (committed entry exists). In REQ, ToCacheReq=1 with head entry fields held stable until CacheAck; on CacheAck head+1, ->IDLE.
REQ-018 Drain throughput: at most one entry per two cycles; ToCacheReq low in IDLE.
REQ-019 SBFlash=1: tail <= commit pointer (after applying a same-cycle CommitStore); uncommitted entries discarded; committed entries and an in-progress REQ unaffected; same-cycle enqueue dropped; no ToRobAble for a dropped store.
REQ-020 Full = (head==tail index, wrap bits differ); SBFull combinational from registered pointers; enqueue while full dropped.
REQ-021 Simultaneous enqueue, commit and drain-pop in one cycle SHALL all take effect.
REQ-022 SBEmpty=1 iff head==tail (all bits).

Reset
REQ-023 Rest=1 SHALL set head=commit=tail=0, FSM=IDLE, SBFull=0, SBEmpty=1, ToRobAble=0, ToRobPtr=0, ToRobTrap=0, ToRobTrapCode=0, ToCacheReq=0, ToCacheAddr/Data/Mask/MAT=0.
REQ-024 Rest SHALL take priority over SBFlash, CommitStore and CacheAck; reset during REQ abandons the request.

Configuration
REQ-025 Macro STORE_FWD_EN: when defined, add ports LdQAddr in 32, LdQHit out 1, LdQData out 32, LdQConflict out 1; combinational search youngest-to-oldest over valid entries with matching word address; LdQHit=1 and LdQData=entry data if youngest match has mask 1111, LdQConflict=1 if youngest match is partial. When undefined, ports absent and no search logic.

Verification
REQ-026 Reset, enqueue 3 word stores (addr 0x100/0x104/0x108) -> ToRobAble 3 pulses one cycle later, SBEmpty=0, ToCacheReq stays 0.
REQ-027 CommitStore x2, CacheAck one cycle after each Req -> two drains addr 0x100, 0x104, mask 1111, third entry held.
REQ-028 Byte store data 0x000000AB to 0x203 -> ToCacheAddr 0x200, mask 1000, data byte3=0xAB.
REQ-029 Fill 8 entries -> SBFull=1; 9th SBAble dropped, no ToRobAble; one drain -> SBFull=0.
REQ-030 2 committed + 3 uncommitted, SBFlash during REQ -> REQ completes, only 2 drains total, then SBEmpty=1.
REQ-031 SBAble with SBTrap=1, code 7'h3 -> ToRobTrap=1, code 3, no entry allocated.
